// File: rtl/bank_register_mp.sv
// bank_register_mp
// ----------------
// Multi-read-port register file for the ID stage. NUM_RD registered read
// ports each have their own write-through bypass. An init port writes the
// array directly, and a dump engine streams the whole bank to the Debug
// Unit one word per accepted transfer.
//
// Ports:
//   i_clock, i_reset        clock (rising edge), synchronous active-low reset
//   i_enable                pipeline step enable; gates normal writes and reads
//   i_reg_write/i_write_reg/i_write_data   normal write port (from WB)
//   i_read_regs             packed read addresses, port k at [k*ADDR_SIZE +: ADDR_SIZE]
//   o_read_data             packed registered read data, port k at [k*DATA_SIZE +: DATA_SIZE]
//   i_init_enable/i_init_addr/i_init_data  init write port, wins over the normal port
//   i_dump_start            request a full-bank dump (honoured only when idle)
//   i_dump_ready            Debug Unit accepts the current dump word
//   o_dump_valid/o_dump_addr/o_dump_data   current dump word
//   o_dump_busy             dump engine active (SEND or DONE)
//   o_dump_done             one-cycle pulse after the last word is accepted
//
// Dump handshake: a word moves when o_dump_valid && i_dump_ready are both
// high at a rising edge. While valid is high and ready is low, addr, data
// and valid stay stable. The engine's state is fully visible on
// {o_dump_busy, o_dump_done}: 00 = IDLE, 10 = SEND, 11 = DONE.

module bank_register_mp #(
    parameter int DATA_SIZE  = 32,
    parameter int ADDR_SIZE  = 5,
    parameter int BANK_DEPTH = 32,
    parameter int NUM_RD     = 2,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic                          i_reg_write,
    input  logic [ADDR_SIZE-1:0]          i_write_reg,
    input  logic [DATA_SIZE-1:0]          i_write_data,
    input  logic [NUM_RD*ADDR_SIZE-1:0]   i_read_regs,
    output logic [NUM_RD*DATA_SIZE-1:0]   o_read_data,
    input  logic                          i_init_enable,
    input  logic [ADDR_SIZE-1:0]          i_init_addr,
    input  logic [DATA_SIZE-1:0]          i_init_data,
    input  logic                          i_dump_start,
    input  logic                          i_dump_ready,
    output logic                          o_dump_valid,
    output logic [ADDR_SIZE-1:0]          o_dump_addr,
    output logic [DATA_SIZE-1:0]          o_dump_data,
    output logic                          o_dump_busy,
    output logic                          o_dump_done
);

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SEND = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_e;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(BANK_DEPTH - 1);

    logic [DATA_SIZE-1:0]        regs_q [BANK_DEPTH];
    logic [NUM_RD*DATA_SIZE-1:0] rd_data_q, rd_data_d;

    logic                        wr_en;
    logic [ADDR_SIZE-1:0]        wr_addr;
    logic [DATA_SIZE-1:0]        wr_data;
    logic [ADDR_SIZE-1:0]        rd_addr;

    dump_state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]        dump_addr_q, dump_addr_d;
    logic [DATA_SIZE-1:0]        dump_data_q, dump_data_d;
    logic                        dump_valid_q, dump_valid_d;
    logic                        dump_load;
    logic [ADDR_SIZE-1:0]        dump_load_addr;

    // Array write selection: init wins, the normal port needs i_enable.
    // A hardwired-zero register 0 swallows every write aimed at it.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = i_write_reg;
        wr_data = i_write_data;
        if (i_init_enable) begin
            wr_en   = 1'b1;
            wr_addr = i_init_addr;
            wr_data = i_init_data;
        end else if (i_enable && i_reg_write) begin
            wr_en = 1'b1;
        end
        if (ZERO_REG && (wr_addr == '0)) begin
            wr_en = 1'b0;
        end
    end

    // Read ports only update on a plain enabled step; otherwise they hold.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_addr   = '0;
        if (!i_init_enable && i_enable) begin
            for (int k = 0; k < NUM_RD; k++) begin
                rd_addr = i_read_regs[k*ADDR_SIZE +: ADDR_SIZE];
                if (ZERO_REG && (rd_addr == '0)) begin
                    rd_data_d[k*DATA_SIZE +: DATA_SIZE] = '0;
                end else if (BYPASS && i_reg_write && (i_write_reg == rd_addr)) begin
                    rd_data_d[k*DATA_SIZE +: DATA_SIZE] = i_write_data;
                end else begin
                    rd_data_d[k*DATA_SIZE +: DATA_SIZE] = regs_q[rd_addr];
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int i = 0; i < BANK_DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[wr_addr] <= wr_data;
            end
            rd_data_q <= rd_data_d;
        end
    end

    // Dump engine next state. Words are loaded from regs_q as it stands
    // before this edge's write, so a same-edge write is never visible.
    always_comb begin
        state_d        = state_q;
        dump_addr_d    = dump_addr_q;
        dump_data_d    = dump_data_q;
        dump_valid_d   = dump_valid_q;
        dump_load      = 1'b0;
        dump_load_addr = '0;
        case (state_q)
            DUMP_IDLE: begin
                if (i_dump_start) begin
                    dump_load      = 1'b1;
                    dump_load_addr = '0;
                    dump_valid_d   = 1'b1;
                    state_d        = DUMP_SEND;
                end
            end
            DUMP_SEND: begin
                if (dump_valid_q && i_dump_ready) begin
                    if (dump_addr_q == LAST_ADDR) begin
                        dump_valid_d = 1'b0;
                        state_d      = DUMP_DONE;
                    end else begin
                        dump_load      = 1'b1;
                        dump_load_addr = dump_addr_q + 1'b1;
                    end
                end
            end
            DUMP_DONE: begin
                state_d = DUMP_IDLE;
            end
            default: begin
                state_d = DUMP_IDLE;
            end
        endcase
        if (dump_load) begin
            dump_addr_d = dump_load_addr;
            if (ZERO_REG && (dump_load_addr == '0)) begin
                dump_data_d = '0;
            end else begin
                dump_data_d = regs_q[dump_load_addr];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q      <= DUMP_IDLE;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dump_addr_q  <= dump_addr_d;
            dump_data_q  <= dump_data_d;
            dump_valid_q <= dump_valid_d;
        end
    end

    assign o_read_data  = rd_data_q;
    assign o_dump_valid = dump_valid_q;
    assign o_dump_addr  = dump_addr_q;
    assign o_dump_data  = dump_data_q;
    assign o_dump_busy  = (state_q != DUMP_IDLE);
    assign o_dump_done  = (state_q == DUMP_DONE);

endmodule

// File: tb/tb_bank_register_mp.sv
// Bench for bank_register_mp. Two instances share every input: u_a has a
// hardwired-zero r0 with bypass, u_b has a writable r0 without bypass.
// A behavioural model (plain arrays plus a word index for the dump stream)
// predicts every output after each rising edge.

module tb_bank_register_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int NR    = 2;

    // ---------------- clock / reset and stimulus signals ----------------
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            rw = 1'b0;
    logic [AW-1:0]   wr = '0;
    logic [DW-1:0]   wd = '0;
    logic [NR*AW-1:0] rr = '0;
    logic            init_en = 1'b0;
    logic [AW-1:0]   init_a = '0;
    logic [DW-1:0]   init_d = '0;
    logic            start = 1'b0;
    logic            ready = 1'b0;

    always #5 clk = ~clk;

    logic [NR*DW-1:0] rd_a, rd_b;
    logic             dv_a, dv_b, busy_a, busy_b, done_a, done_b;
    logic [AW-1:0]    da_a, da_b;
    logic [DW-1:0]    dd_a, dd_b;

    bank_register_mp #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .BANK_DEPTH(DEPTH),
                       .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_a (
        .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_reg_write(rw),
        .i_write_reg(wr), .i_write_data(wd), .i_read_regs(rr), .o_read_data(rd_a),
        .i_init_enable(init_en), .i_init_addr(init_a), .i_init_data(init_d),
        .i_dump_start(start), .i_dump_ready(ready), .o_dump_valid(dv_a),
        .o_dump_addr(da_a), .o_dump_data(dd_a), .o_dump_busy(busy_a), .o_dump_done(done_a)
    );

    bank_register_mp #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .BANK_DEPTH(DEPTH),
                       .NUM_RD(NR), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
        .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_reg_write(rw),
        .i_write_reg(wr), .i_write_data(wd), .i_read_regs(rr), .o_read_data(rd_b),
        .i_init_enable(init_en), .i_init_addr(init_a), .i_init_data(init_d),
        .i_dump_start(start), .i_dump_ready(ready), .o_dump_valid(dv_b),
        .o_dump_addr(da_b), .o_dump_data(dd_b), .o_dump_busy(busy_b), .o_dump_done(done_b)
    );

    // ---------------- reference model ----------------
    // Index 0 models u_a (zero r0, bypass), index 1 models u_b.
    logic [DW-1:0] m_regs [2][DEPTH];
    logic [DW-1:0] m_rd   [2][NR];
    logic [DW-1:0] m_data [2];
    int            m_phase;   // 0 idle, 1 streaming words, 2 done pulse
    int            m_idx;
    logic          m_valid;

    int n_vec = 0;
    int n_err = 0;
    logic [AW-1:0] got_q[$];
    logic [AW-1:0] exp_q[$];

    function automatic logic [DW-1:0] m_read(int d, logic [AW-1:0] a);
        if (d == 0 && a == 0) return '0;
        if (d == 0 && rw && wr == a) return wd;
        return m_regs[d][a];
    endfunction

    function automatic logic [DW-1:0] m_snap(int d, int a);
        if (d == 0 && a == 0) return '0;
        return m_regs[d][a];
    endfunction

    task automatic model_edge();
        logic [AW-1:0] a;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < DEPTH; i++) m_regs[d][i] = '0;
                for (int k = 0; k < NR; k++) m_rd[d][k] = '0;
                m_data[d] = '0;
            end
            m_phase = 0; m_idx = 0; m_valid = 1'b0;
        end else begin
            // dump stream sees the array before this edge's writes
            if (m_phase == 0) begin
                if (start) begin
                    m_idx = 0; m_valid = 1'b1; m_phase = 1;
                    for (int d = 0; d < 2; d++) m_data[d] = m_snap(d, 0);
                end
            end else if (m_phase == 1) begin
                if (ready) begin
                    if (m_idx == DEPTH - 1) begin
                        m_valid = 1'b0; m_phase = 2;
                    end else begin
                        m_idx++;
                        for (int d = 0; d < 2; d++) m_data[d] = m_snap(d, m_idx);
                    end
                end
            end else begin
                m_phase = 0;
            end
            for (int d = 0; d < 2; d++) begin
                if (init_en) begin
                    if (!(d == 0 && init_a == 0)) m_regs[d][init_a] = init_d;
                end else if (en) begin
                    for (int k = 0; k < NR; k++) begin
                        a = rr[k*AW +: AW];
                        m_rd[d][k] = m_read(d, a);
                    end
                    if (rw && !(d == 0 && wr == 0)) m_regs[d][wr] = wd;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("miscompare in %s", tag);
        end
    endtask

    task automatic check_all();
        chk("rd_a", rd_a, {m_rd[0][1], m_rd[0][0]});
        chk("rd_b", rd_b, {m_rd[1][1], m_rd[1][0]});
        chk("dump_valid", {62'd0, dv_a, dv_b}, {62'd0, m_valid, m_valid});
        chk("dump_busy", {62'd0, busy_a, busy_b}, {62'd0, m_phase != 0, m_phase != 0});
        chk("dump_done", {62'd0, done_a, done_b}, {62'd0, m_phase == 2, m_phase == 2});
        chk("dump_addr", {54'd0, da_a, da_b}, {54'd0, AW'(m_idx), AW'(m_idx)});
        chk("dump_data", {dd_a, dd_b}, {m_data[0], m_data[1]});
    endtask

    // one rising edge: predict, clock, then sample 1 ns after the edge
    task automatic cycle();
        if (rst_n && dv_a && ready) got_q.push_back(da_a);
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic quiet();
        en = 1'b1; rw = 1'b0; init_en = 1'b0; start = 1'b0;
    endtask

    task automatic rand_traffic();
        en      = 1'($urandom_range(0, 1));
        rw      = 1'($urandom_range(0, 1));
        wr      = AW'($urandom_range(0, DEPTH - 1));
        wd      = $urandom;
        init_en = ($urandom_range(0, 7) == 0);
        init_a  = AW'($urandom_range(0, DEPTH - 1));
        init_d  = $urandom;
        rr      = NR*AW'($urandom);
    endtask

    task automatic check_stream(input string tag);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(AW'(i));
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < DEPTH && i < got_q.size(); i++)
            chk({tag, "_order"}, 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n = 1'b0;
        cycle();
        cycle();
        chk("reset_rd_a", rd_a, 64'd0);
        chk("reset_busy", {63'd0, busy_a}, 64'd0);
        rst_n = 1'b1;

        // init every register with 0x100+addr (r0 discarded in u_a)
        en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            init_en = 1'b1; init_a = AW'(i); init_d = 32'h100 + i;
            cycle();
        end
        quiet();
        rr = {5'd31, 5'd5};
        cycle();
        chk("read_5_31", rd_a, 64'h0000011F_00000105);

        // same-cycle write and read of r7 on both ports
        rw = 1'b1; wr = 5'd7; wd = 32'hDEADBEEF; rr = {5'd7, 5'd7};
        cycle();
        chk("bypass_r7", rd_a, 64'hDEADBEEF_DEADBEEF);
        chk("nobypass_r7", rd_b, 64'h00000107_00000107);
        rw = 1'b0;
        cycle();
        chk("r7_after", rd_b, 64'hDEADBEEF_DEADBEEF);

        // writes to r0 through both write paths
        rw = 1'b1; wr = 5'd0; wd = 32'h1234; rr = {5'd0, 5'd0};
        cycle();
        rw = 1'b0; init_en = 1'b1; init_a = 5'd0; init_d = 32'h1234;
        cycle();
        quiet();
        cycle();
        chk("zero_r0", rd_a, 64'd0);
        chk("plain_r0", rd_b, 64'h00001234_00001234);

        // full dump, ready held high, random writes underway
        got_q.delete();
        start = 1'b1; ready = 1'b1;
        cycle();
        start = 1'b0;
        chk("dump_w0_zero", {32'd0, dd_a}, 64'd0);
        chk("dump_w0_plain", {32'd0, dd_b}, 64'h1234);
        for (int i = 0; i < 60 && m_phase != 0; i++) begin
            rand_traffic();
            cycle();
        end
        quiet();
        chk("dump1_idle", {63'd0, busy_a}, 64'd0);
        check_stream("dump1");

        // dump with ready 1,0,0 repeating and a stray start mid-dump
        got_q.delete();
        start = 1'b1; ready = 1'b0;
        cycle();
        for (int i = 0; i < 200 && m_phase != 0; i++) begin
            rand_traffic();
            start = (i == 10);
            ready = (i % 3 == 0);
            cycle();
        end
        quiet();
        chk("dump2_idle", {63'd0, busy_a}, 64'd0);
        check_stream("dump2");

        // reset while the stream sits at address 10
        start = 1'b1; ready = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 40 && m_idx != 10; i++) cycle();
        chk("at_addr10", {59'd0, da_a}, 64'd10);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1; ready = 1'b0;
        chk("abort_valid", {63'd0, dv_a}, 64'd0);
        chk("abort_busy", {63'd0, busy_a}, 64'd0);
        cycle();
        chk("abort_nodone", {63'd0, done_a}, 64'd0);
        for (int i = 0; i < DEPTH; i += 2) begin
            rr = {AW'(i + 1), AW'(i)};
            cycle();
            chk("cleared", rd_b, 64'd0);
        end
        got_q.delete();
        start = 1'b1; ready = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 60 && m_phase != 0; i++) cycle();
        check_stream("dump3");

        // free-running random traffic
        for (int i = 0; i < 600; i++) begin
            rand_traffic();
            ready = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
